// File: rtl/sound_glu_pkg.sv
// sound_glu_pkg: shared constants and types for the sound GLU.
//   - soft-switch register offsets ($C03C..$C03F)
//   - control register bit indices
//   - FSM state encoding
//   - DOC OIR address (a read pops the oscillator interrupt FIFO)
package sound_glu_pkg;
  localparam logic [1:0] GLU_CTRL = 2'd0;
  localparam logic [1:0] GLU_DATA = 2'd1;
  localparam logic [1:0] GLU_PTRL = 2'd2;
  localparam logic [1:0] GLU_PTRH = 2'd3;

  localparam int BUSY    = 7;
  localparam int TARGET  = 6;
  localparam int AUTOINC = 5;

  localparam logic [7:0] DOC_OIR_ADDR = 8'hE0;

  typedef enum logic [1:0] {IDLE, WRITE, ISSUE, CAPTURE} glu_state_t;
endpackage

// File: rtl/sound_glu.sv
// sound_glu: CPU-side sound interface controller.
// Decodes $C03C-$C03F and sequences DOC register / sound-RAM cycles.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cpu_sel/addr/we/din/dout    soft-switch register access
//   doc_wr/reg_addr/din/dout    ES5503 register port
//   ram_addr/we/din/dout        sound-RAM CPU port (1-cycle read latency)
//   busy, volume                status and master volume
module sound_glu
  import sound_glu_pkg::*;
#(
  parameter logic [7:0] PARK_ADDR = 8'hE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_sel,
  input  logic [1:0]  cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        doc_wr,
  output logic [7:0]  doc_reg_addr,
  output logic [7:0]  doc_din,
  input  logic [7:0]  doc_dout,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        busy,
  output logic [3:0]  volume
);
  glu_state_t  r_state;
  logic        r_target, r_autoinc, r_op_tgt;
  logic [3:0]  r_volume;
  logic [15:0] r_ptr;
  logic [7:0]  r_latch;
  logic        r_doc_wr, r_ram_we;
  logic [7:0]  r_doc_addr, r_doc_din, r_ram_din;
  logic [15:0] r_ram_addr;

  logic w_busy, w_acc;
  assign w_busy = (r_state != IDLE);
  assign w_acc  = cpu_sel && (cpu_addr == GLU_DATA) && !w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_target   <= 1'b0;
      r_autoinc  <= 1'b0;
      r_volume   <= 4'h0;
      r_op_tgt   <= 1'b0;
      r_ptr      <= 16'h0000;
      r_latch    <= 8'h00;
      r_doc_wr   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_doc_addr <= PARK_ADDR;
      r_doc_din  <= 8'h00;
      r_ram_addr <= 16'h0000;
      r_ram_din  <= 8'h00;
    end else begin
      r_doc_wr <= 1'b0;
      r_ram_we <= 1'b0;

      // Ctrl/ptr accesses are honoured even mid-operation; the op in
      // flight has already copied what it needs onto the output regs.
      if (cpu_sel && cpu_we) begin
        case (cpu_addr)
          GLU_CTRL: begin
            r_target  <= cpu_din[TARGET];
            r_autoinc <= cpu_din[AUTOINC];
            r_volume  <= cpu_din[3:0];
          end
          GLU_PTRL: r_ptr[7:0]  <= cpu_din;
          GLU_PTRH: r_ptr[15:8] <= cpu_din;
          default:  ;
        endcase
      end
      if (w_acc && r_autoinc) r_ptr <= r_ptr + 16'd1;

      case (r_state)
        IDLE: if (w_acc) begin
          // The pointer snapshot goes straight onto the bus registers.
          r_op_tgt <= r_target;
          if (cpu_we) begin
            r_state <= WRITE;
            if (r_target) begin
              r_ram_we   <= 1'b1;
              r_ram_addr <= r_ptr;
              r_ram_din  <= cpu_din;
            end else begin
              r_doc_wr   <= 1'b1;
              r_doc_addr <= r_ptr[7:0];
              r_doc_din  <= cpu_din;
            end
          end else begin
            r_state <= ISSUE;
            if (r_target) r_ram_addr <= r_ptr;
            else          r_doc_addr <= r_ptr[7:0];
          end
        end
        WRITE: begin
          r_state    <= IDLE;
          r_doc_addr <= PARK_ADDR;
        end
        ISSUE: begin
          // Park now: the DOC has already registered the read address.
          r_state    <= CAPTURE;
          r_doc_addr <= PARK_ADDR;
        end
        CAPTURE: begin
          r_state <= IDLE;
          r_latch <= r_op_tgt ? ram_dout : doc_dout;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so an aborted op never writes.
  assign doc_wr       = r_doc_wr & ~reset;
  assign ram_we       = r_ram_we & ~reset;
  assign doc_reg_addr = r_doc_addr;
  assign doc_din      = r_doc_din;
  assign ram_addr     = r_ram_addr;
  assign ram_din      = r_ram_din;
  assign busy         = w_busy;
  assign volume       = r_volume;

  always_comb begin
    cpu_dout = 8'h00;
    case (cpu_addr)
      GLU_CTRL: cpu_dout = {w_busy, r_target, r_autoinc, 1'b0, r_volume};
      GLU_DATA: cpu_dout = r_latch;
      GLU_PTRL: cpu_dout = r_ptr[7:0];
      GLU_PTRH: cpu_dout = r_ptr[15:8];
      default:  cpu_dout = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_sound_glu.sv
module tb_sound_glu;
  import sound_glu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_sel, cpu_we;
  logic [1:0]  cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        doc_wr, ram_we, busy;
  logic [7:0]  doc_reg_addr, doc_din, doc_dout, ram_din, ram_dout;
  logic [15:0] ram_addr;
  logic [3:0]  volume;

  sound_glu dut (
    .clk(clk), .reset(reset), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .doc_wr(doc_wr), .doc_reg_addr(doc_reg_addr), .doc_din(doc_din),
    .doc_dout(doc_dout), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .volume(volume)
  );

  always #5 clk = ~clk;

  // DOC register file and sound RAM models
  logic [7:0] docmem [256];
  logic [7:0] mem    [65536];
  always @(posedge clk) begin
    doc_dout <= docmem[doc_reg_addr];
    if (doc_wr) docmem[doc_reg_addr] <= doc_din;
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  typedef struct packed {
    logic        tgt;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  int vecs = 0, miss = 0;
  int e0_cnt = 0, nonpark = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (doc_reg_addr == DOC_OIR_ADDR) e0_cnt++;
    if (doc_reg_addr != 8'hE1) nonpark++;
    if (doc_wr || ram_we) begin
      wr_t o, e;
      o = doc_wr ? {1'b0, 8'h00, doc_reg_addr, doc_din} : {1'b1, ram_addr, ram_din};
      vecs++;
      assert (wq.size() != 0) else begin
        miss++;
        $error("FAIL unexpected_write: observed %h expected none", o);
      end
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("write", o[15:0], e[15:0]);
        chk("write_hi", {7'd0, o[24:16]}, {7'd0, e[24:16]});
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic we, input logic [7:0] d);
    cpu_sel = 1'b1; cpu_addr = a; cpu_we = we; cpu_din = d;
    tick();
    cpu_sel = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] o, e;
    rq.push_back(exp);
    cpu_sel = 1'b1; cpu_addr = a; cpu_we = 1'b0;
    @(negedge clk);
    o = cpu_dout;
    e = rq.pop_front();
    chk(tag, {8'h00, o}, {8'h00, e});
    tick();
    cpu_sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = 2'd0; cpu_din = 8'h00;
    for (int i = 0; i < 256; i++) docmem[i] = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_doc_addr", {8'd0, doc_reg_addr}, 16'h00E1);
    chk("rst_ram_addr", ram_addr, 16'h0000);
    chk("rst_volume", {12'd0, volume}, 16'd0);
    chk("rst_strobes", {14'd0, doc_wr, ram_we}, 16'd0);

    // DOC writes with auto-increment
    drive(GLU_CTRL, 1, 8'h20);
    drive(GLU_PTRL, 1, 8'hA0);
    drive(GLU_PTRH, 1, 8'h00);
    wq.push_back({1'b0, 16'h00A0, 8'h5A});
    drive(GLU_DATA, 1, 8'h5A); tick();
    wq.push_back({1'b0, 16'h00A1, 8'h5A});
    drive(GLU_DATA, 1, 8'h5A); tick();
    rd(GLU_PTRL, 8'hA2, "doc_ptrl");
    rd(GLU_PTRH, 8'h00, "doc_ptrh");
    rd(GLU_CTRL, 8'h20, "ctrl_20");
    chk("doc_park_after_wr", {8'd0, doc_reg_addr}, 16'h00E1);
    drive(GLU_CTRL, 1, 8'h7F);
    rd(GLU_CTRL, 8'h6F, "ctrl_7f");
    chk("volume_f", {12'd0, volume}, 16'h000F);

    // RAM write with pointer wrap
    drive(GLU_CTRL, 1, 8'h60);
    drive(GLU_PTRL, 1, 8'hFF);
    drive(GLU_PTRH, 1, 8'hFF);
    wq.push_back({1'b1, 16'hFFFF, 8'h33});
    drive(GLU_DATA, 1, 8'h33); tick();
    rd(GLU_PTRL, 8'h00, "wrap_ptrl");
    rd(GLU_PTRH, 8'h00, "wrap_ptrh");
    chk("ram_ffff", {8'd0, mem[16'hFFFF]}, 16'h0033);
    chk("ram_addr_hold", ram_addr, 16'hFFFF);

    // RAM reads: one-behind pipeline
    mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22;
    drive(GLU_PTRL, 1, 8'h00);
    drive(GLU_PTRH, 1, 8'h10);
    rd(GLU_DATA, 8'h00, "rd0_stale"); tick(); tick();
    rd(GLU_DATA, 8'h11, "rd1");       tick(); tick();
    rd(GLU_DATA, 8'h22, "rd2");       tick(); tick();
    rd(GLU_PTRL, 8'h03, "rd_ptrl");
    rd(GLU_PTRH, 8'h10, "rd_ptrh");

    // data write while busy is dropped
    mem[16'h2001] = 8'h77;
    drive(GLU_PTRL, 1, 8'h00);
    drive(GLU_PTRH, 1, 8'h20);
    wq.push_back({1'b1, 16'h2000, 8'hAA});
    drive(GLU_DATA, 1, 8'hAA);
    chk("busy_t1", {15'd0, busy}, 16'd1);
    drive(GLU_DATA, 1, 8'hBB);
    rd(GLU_PTRL, 8'h01, "drop_ptrl");
    rd(GLU_DATA, 8'h00, "rd_1002");
    rd(GLU_CTRL, 8'hE0, "ctrl_busy");
    tick();
    rd(GLU_DATA, 8'h77, "rd_2001"); tick(); tick();
    chk("ram_2001_kept", {8'd0, mem[16'h2001]}, 16'h0077);

    // DOC park address while idle; OIR touched for one cycle only
    drive(GLU_CTRL, 1, 8'h00);
    drive(GLU_PTRL, 1, 8'hE0);
    docmem[8'hE0] = 8'h5C;
    nonpark = 0;
    repeat (100) tick();
    chk("idle_park", nonpark[15:0], 16'd0);
    e0_cnt = 0;
    rd(GLU_DATA, 8'h00, "rd_2002"); tick(); tick(); tick();
    chk("oir_once", e0_cnt[15:0], 16'd1);
    rd(GLU_DATA, 8'h5C, "rd_oir"); tick(); tick();

    // reset at T1 of a RAM write aborts it
    drive(GLU_CTRL, 1, 8'h6A);
    drive(GLU_PTRL, 1, 8'h00);
    drive(GLU_PTRH, 1, 8'h30);
    drive(GLU_DATA, 1, 8'h99);
    reset = 1'b1;
    #1 chk("abort_ram_we", {15'd0, ram_we}, 16'd0);
    @(posedge clk); #1 reset = 1'b0;
    chk("post_busy", {15'd0, busy}, 16'd0);
    chk("post_doc_addr", {8'd0, doc_reg_addr}, 16'h00E1);
    chk("post_ram_addr", ram_addr, 16'h0000);
    chk("post_ram_din", {8'd0, ram_din}, 16'h0000);
    chk("post_doc_din", {8'd0, doc_din}, 16'h0000);
    chk("post_volume", {12'd0, volume}, 16'd0);
    rd(GLU_CTRL, 8'h00, "post_ctrl");
    rd(GLU_PTRH, 8'h00, "post_ptrh");
    rd(GLU_DATA, 8'h00, "post_latch"); tick(); tick();
    chk("ram_3000_clean", {8'd0, mem[16'h3000]}, 16'h0000);

    chk("pending_writes", wq.size(), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
